// File: rtl/fp_max_pool_if.sv
// Stream bundle between the float datapath and the max-pool reducer.
// Input side: input_a / input_a_stb from upstream, input_a_ack back to it.
// Output side: output_z / output_z_stb to downstream, output_z_ack back from it.
interface fp_max_pool_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    // The reducer sits on the slave side; the producer/consumer pair drives master.
    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack
    );

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack
    );
endinterface

// File: rtl/fp_max_pool.sv
// Purpose: streaming IEEE-754 single max-pool; emits the max of every POOL_SIZE inputs (any NaN -> 7FC00000).
// Latency: 2 cycles per accepted input; output_z_stb rises 1 cycle after the last transfer of a window.
// Backpressure: input_a_ack is low while the window result waits for output_z_ack, for as long as it takes.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries input_a/_stb/_ack and output_z/_stb/_ack.
module fp_max_pool #(
    parameter int POOL_SIZE = 4,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    fp_max_pool_if.slave  bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        CMP   = 2'd1,
        PUT_Z = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      a_q;
    logic [31:0]      max_q;
    logic [31:0]      z_q;
    logic             nan_q;
    logic             z_stb_q;
    logic             a_ack_q;

    // Order-preserving unsigned key: positives sit above 0x8000_0000, negatives
    // below it by their magnitude, so +0 and -0 both land on 0x8000_0000 and tie.
    function automatic logic [31:0] order_key(input logic [31:0] f);
        if (f[31]) begin
            return 32'h8000_0000 - {1'b0, f[30:0]};
        end
        return 32'h8000_0000 + {1'b0, f[30:0]};
    endfunction

    logic        a_is_nan;
    logic        take_a;
    logic        last_elem;
    logic [31:0] max_d;

    assign a_is_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    // Strict compare keeps the earliest of equal maxima (including the sign of zero).
    assign take_a    = (count_q == '0) || (order_key(a_q) > order_key(max_q));
    assign max_d     = take_a ? a_q : max_q;
    assign last_elem = (count_q == CNT_W'(POOL_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            count_q <= '0;
            a_q     <= '0;
            max_q   <= '0;
            nan_q   <= 1'b0;
            z_q     <= '0;
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (a_ack_q && bus.input_a_stb) begin
                        a_q     <= bus.input_a;
                        a_ack_q <= 1'b0;
                        state_q <= CMP;
                    end else begin
                        // Raises ack on the first cycle out of reset.
                        a_ack_q <= 1'b1;
                    end
                end
                CMP: begin
                    max_q <= max_d;
                    if (last_elem) begin
                        // NaN seen anywhere in the window, including this last
                        // element, overrides the ordered maximum.
                        z_q     <= (nan_q || a_is_nan) ? QNAN : max_d;
                        z_stb_q <= 1'b1;
                        count_q <= '0;
                        nan_q   <= 1'b0;
                        state_q <= PUT_Z;
                    end else begin
                        if (a_is_nan) begin
                            nan_q <= 1'b1;
                        end
                        count_q <= count_q + CNT_W'(1);
                        a_ack_q <= 1'b1;
                        state_q <= GET_A;
                    end
                end
                PUT_Z: begin
                    if (bus.output_z_ack) begin
                        z_stb_q <= 1'b0;
                        a_ack_q <= 1'b1;
                        state_q <= GET_A;
                    end
                end
                default: begin
                    state_q <= GET_A;
                end
            endcase
        end
    end

    assign bus.input_a_ack  = a_ack_q;
    assign bus.output_z     = z_q;
    assign bus.output_z_stb = z_stb_q;

endmodule
